// File: rtl/mem_io_responder_if.sv
// Byte-wide memory request/response bus between the CPU memory controller and its responder.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    modport master (output mem_a, output mem_wr, output mem_dout, input mem_din);
    modport slave  (input mem_a, input mem_wr, input mem_dout, output mem_din);
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM plus a small I/O window (UART TX FIFO, RX holding
// register, halt port) answering one byte request per cycle with 1-cycle read latency.
module mem_io_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_LOG   = 3,
    parameter string       INIT_FILE  = ""
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_io_responder_if.slave         bus,
    output logic                      io_buffer_full,
    output logic [7:0]                uart_tx_data,
    output logic                      uart_tx_valid,
    input  logic                      uart_tx_ready,
    input  logic [7:0]                uart_rx_data,
    input  logic                      uart_rx_valid,
    output logic                      halt,
    output logic [7:0]                halt_code,
    output logic                      tx_overflow
);

    localparam int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_LOG;
    localparam int unsigned CNT_W      = FIFO_LOG + 1;

    logic [7:0] ram  [RAM_DEPTH];
    logic [7:0] fifo [FIFO_DEPTH];

    logic [FIFO_LOG-1:0] wr_ptr;
    logic [FIFO_LOG-1:0] rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [7:0]          rx_byte;
    logic                rx_full;

    logic [ADDR_WIDTH-1:0] idx;
    logic [15:0]           io_off;
    logic                  is_io;
    logic                  ram_we;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  rx_rd;
    logic                  halt_wr;
    logic                  unused_addr;

    // Address decode: bits [31:18] are ignored, [17:16]==2'b11 selects the I/O window
    assign idx         = bus.mem_a[ADDR_WIDTH-1:0];
    assign io_off      = bus.mem_a[15:0];
    assign is_io       = (bus.mem_a[17:16] == 2'b11);
    assign unused_addr = ^bus.mem_a[31:18];

    assign ram_we    = bus.mem_wr && !is_io;
    assign push_req  = bus.mem_wr && is_io && (io_off == 16'h0000);
    assign halt_wr   = bus.mem_wr && is_io && (io_off == 16'h0004);
    assign rx_rd     = !bus.mem_wr && is_io && (io_off == 16'h0000);
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = uart_tx_valid && uart_tx_ready;
    // A pop in the same cycle frees the slot, so a push while full is still accepted
    assign push      = push_req && (!fifo_full || pop);

    assign uart_tx_valid  = (count != '0);
    assign uart_tx_data   = fifo[rd_ptr];
    // Asserted one entry early so an in-flight write still has a slot
    assign io_buffer_full = (count >= CNT_W'(FIFO_DEPTH - 1));

    // Storage arrays: no reset, RAM contents survive rst
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx] <= bus.mem_dout;
        end
        if (push) begin
            fifo[wr_ptr] <= bus.mem_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_din <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_byte     <= 8'h00;
            rx_full     <= 1'b0;
            halt        <= 1'b0;
            halt_code   <= 8'h00;
            tx_overflow <= 1'b0;
        end else begin
            if (!bus.mem_wr) begin
                if (!is_io) begin
                    bus.mem_din <= ram[idx];
                end else if (io_off == 16'h0000) begin
                    bus.mem_din <= rx_full ? rx_byte : 8'h00;
                end else begin
                    bus.mem_din <= 8'h00;
                end
            end

            // A read of the RX register empties it before a same-cycle strobe is captured
            if (rx_rd) begin
                rx_full <= 1'b0;
            end
            if (uart_rx_valid && (!rx_full || rx_rd)) begin
                rx_byte <= uart_rx_data;
                rx_full <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + FIFO_LOG'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_LOG'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && !push) begin
                tx_overflow <= 1'b1;
            end

            if (halt_wr) begin
                halt      <= 1'b1;
                halt_code <= bus.mem_dout;
            end
        end
    end

endmodule
